// File: rtl/chatter_counter.sv
// Switch debouncer: two-flop synchronizer feeding a qualification counter,
// with a debounced level output and a toggle flag that flips on each accepted press.
module chatter_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int THRESHOLD = 200
) (
  input  logic                 chatterclock,
  input  logic                 reset,
  input  logic                 switchin,
  output logic                 enabled,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ispressed
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(THRESHOLD - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ispressed_q, ispressed_d;
  logic                 enabled_q, enabled_d;

  always_comb begin
    sync1_d     = switchin;
    sync2_d     = sync1_q;
    count_d     = count_q;
    ispressed_d = ispressed_q;
    enabled_d   = enabled_q;
    // A sample agreeing with the current level aborts any qualification in progress.
    if (sync2_q == ispressed_q) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      ispressed_d = sync2_q;
      count_d     = '0;
      if (sync2_q) begin
        enabled_d = ~enabled_q;
      end
    end else begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge chatterclock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      count_q     <= '0;
      ispressed_q <= 1'b0;
      enabled_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      count_q     <= count_d;
      ispressed_q <= ispressed_d;
      enabled_q   <= enabled_d;
    end
  end

  assign count     = count_q;
  assign ispressed = ispressed_q;
  assign enabled   = enabled_q;

endmodule

// File: tb/tb_chatter_counter.sv
// Scenario bench for chatter_counter: one instance at THRESHOLD=4, one at THRESHOLD=1,
// hand-derived expected outputs queued per cycle and compared after each rising edge.
module tb_chatter_counter;

  localparam int W = 8;
  localparam int PRESS_C [6] = '{0, 0, 1, 2, 3, 0};

  typedef struct packed {
    logic [W-1:0] count;
    logic         isp;
    logic         en;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst4, sw4, en4, isp4;
  logic [W-1:0] cnt4;
  logic         rst1, sw1, en1, isp1;
  logic [W-1:0] cnt1;

  exp_t q4[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chatter_counter #(.CNT_WIDTH(W), .THRESHOLD(4)) dut4 (
    .chatterclock(clk), .reset(rst4), .switchin(sw4),
    .enabled(en4), .count(cnt4), .ispressed(isp4)
  );

  chatter_counter #(.CNT_WIDTH(W), .THRESHOLD(1)) dut1 (
    .chatterclock(clk), .reset(rst1), .switchin(sw1),
    .enabled(en1), .count(cnt1), .ispressed(isp1)
  );

  // Drive one cycle of stimulus, queue what the outputs must be after that edge.
  task automatic drive4(input logic sw, input logic rst, input int c, input logic p, input logic e);
    @(negedge clk);
    sw4  = sw;
    rst4 = rst;
    q4.push_back(exp_t'{W'(c), p, e});
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic sw, input logic rst, input int c, input logic p, input logic e);
    @(negedge clk);
    sw1  = sw;
    rst1 = rst;
    q1.push_back(exp_t'{W'(c), p, e});
    @(posedge clk);
    #1;
  endtask

  task automatic settle4();
    repeat (2) begin @(negedge clk); sw4 = 1'b0; rst4 = 1'b1; end
    repeat (2) begin @(negedge clk); sw4 = 1'b0; rst4 = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int   sw [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    int   rs [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int   c  [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
    int   p  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    exp_t exp;
    for (int i = 0; i < 8; i++) begin
      drive4(sw[i][0], rs[i][0], c[i], p[i][0], p[i][0]);
      exp = q4.pop_front();
      checks++;
      if ({cnt4, isp4, en4} !== exp) begin
        failures++;
        $display("[TB] FAIL reset step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                 i, cnt4, isp4, en4, exp.count, exp.isp, exp.en);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t exp;
    settle4();
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 1'b0, (i < 6) ? PRESS_C[i] : 0, i >= 5, i >= 5);
      exp = q4.pop_front();
      checks++;
      if ({cnt4, isp4, en4} !== exp) begin
        failures++;
        $display("[TB] FAIL clean_press step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                 i, cnt4, isp4, en4, exp.count, exp.isp, exp.en);
      end
    end
  endtask

  task automatic test_bounce();
    int   sw [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int   c  [10] = '{0, 0, 1, 2, 0, 1, 2, 3, 0, 0};
    exp_t exp;
    settle4();
    for (int i = 0; i < 10; i++) begin
      drive4(sw[i][0], 1'b0, c[i], i >= 8, i >= 8);
      exp = q4.pop_front();
      checks++;
      if ({cnt4, isp4, en4} !== exp) begin
        failures++;
        $display("[TB] FAIL bounce step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                 i, cnt4, isp4, en4, exp.count, exp.isp, exp.en);
      end
    end
  endtask

  task automatic test_toggle();
    logic s;
    logic e_exp = 1'b0;
    exp_t exp;
    settle4();
    for (int ph = 0; ph < 4; ph++) begin
      s = (ph % 2 == 0);
      for (int i = 0; i < 6; i++) begin
        if (i == 5 && s) e_exp = ~e_exp;
        drive4(s, 1'b0, PRESS_C[i], (i == 5) ? s : ~s, e_exp);
        exp = q4.pop_front();
        checks++;
        if ({cnt4, isp4, en4} !== exp) begin
          failures++;
          $display("[TB] FAIL toggle phase %0d step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                   ph, i, cnt4, isp4, en4, exp.count, exp.isp, exp.en);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Two runs: reset at count=2, and reset on the very edge the threshold would hit.
    int   sw [2][8] = '{'{1, 1, 1, 1, 1, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 0}};
    int   rs [2][8] = '{'{0, 0, 0, 0, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 1, 1, 0}};
    int   c  [2][8] = '{'{0, 0, 1, 2, 0, 0, 0, 0}, '{0, 0, 1, 2, 3, 0, 0, 0}};
    exp_t exp;
    for (int r = 0; r < 2; r++) begin
      settle4();
      for (int i = 0; i < 8; i++) begin
        drive4(sw[r][i][0], rs[r][i][0], c[r][i], 1'b0, 1'b0);
        exp = q4.pop_front();
        checks++;
        if ({cnt4, isp4, en4} !== exp) begin
          failures++;
          $display("[TB] FAIL reset_mid run %0d step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                   r, i, cnt4, isp4, en4, exp.count, exp.isp, exp.en);
        end
      end
    end
  endtask

  task automatic test_threshold_one();
    int   sw [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int   rs [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int   p  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int   e  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    exp_t exp;
    for (int i = 0; i < 10; i++) begin
      drive1(sw[i][0], rs[i][0], 0, p[i][0], e[i][0]);
      exp = q1.pop_front();
      checks++;
      if ({cnt1, isp1, en1} !== exp) begin
        failures++;
        $display("[TB] FAIL threshold_one step %0d: got count=%0d isp=%b en=%b, want count=%0d isp=%b en=%b",
                 i, cnt1, isp1, en1, exp.count, exp.isp, exp.en);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sw4  = 1'b0;
    rst4 = 1'b1;
    sw1  = 1'b0;
    rst1 = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_toggle();
    test_reset_mid();
    test_threshold_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chatter_counter.md
Name: chatter_counter

Overview:
- Debounces one raw mechanical switch input. Produces a clean level (ispressed) and a toggle flag (enabled) that flips on every debounced press.
- Exposes the live debounce counter for display and debug.
- Used by the top-level controller for the exec and reset push-buttons. enabled gates the stage clocks (run/hold toggle).

Parameters:
- CNT_WIDTH, 8, width of the debounce counter and the count port.
- THRESHOLD, 200, number of consecutive disagreeing synchronized samples required to accept a new level; legal range 1 .. 2^CNT_WIDTH.

Ports:
- chatterclock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- switchin  input  1  raw asynchronous switch level; 1 = pressed.
- enabled  output  1  toggle flag; inverts on each debounced 0->1 transition of ispressed.
- count  output  CNT_WIDTH  current debounce counter value.
- ispressed  output  1  debounced switch level.

Behaviour:
- All outputs are registered; no combinational path from switchin to any output.
- Synchronizer: two flops, sync1 <= switchin, then sync2 <= sync1. Only sync2 feeds the debounce logic.
- Reset (reset=1 at a rising edge):
  - sync1, sync2, count, ispressed and enabled all go to 0.
  - Reset has priority over every other update, including mid-count and in the same cycle as a threshold hit.
- Debounce, evaluated each rising edge when not in reset:
  - If sync2 == ispressed: count <= 0 (stable, or a glitch aborts the attempt).
  - Else if count == THRESHOLD-1: ispressed <= sync2 and count <= 0. If sync2 == 1 (press accepted), also enabled <= ~enabled.
  - Else: count <= count + 1.
- Latency: a new switchin level first captured by sync1 at edge k, and held, updates ispressed at edge k+THRESHOLD+1. With THRESHOLD=1 that is edge k+2.
- Release (1->0) is debounced identically and does not affect enabled.
- Any single sample matching the current ispressed restarts the qualification from 0. Count never exceeds THRESHOLD-1, so it never wraps.
- enabled toggles at most once per accepted press, in the same edge ispressed rises.
- Holding the switch down does not re-toggle enabled.

Test Plan:
- Reset (THRESHOLD=4): assert reset 2 cycles with switchin=1 -> ispressed=0, enabled=0, count=0 on the cycle after reset; after release, ispressed rises 5 edges after sync1 captures 1.
- Clean press (THRESHOLD=4): switchin 0->1 held -> count sequence 0,1,2,3,0 over successive edges; ispressed=1 and enabled=1 at the edge count returns to 0.
- Bounce (THRESHOLD=4): switchin pattern 1,1,0,1,1,1,1,1 (one sample per cycle) -> count resets to 0 after the 0 sample; ispressed rises only after 4 consecutive synchronized 1s; enabled toggles exactly once.
- Toggle: two full press/release cycles -> enabled goes 0->1->0; releases change ispressed to 0 after the same 5-edge latency with enabled unchanged.
- Reset mid-count (THRESHOLD=4): assert reset when count=2 -> count=0, ispressed=0, enabled=0 next edge; no toggle occurs.
- Edge case THRESHOLD=1: single stable 1 -> ispressed=1 at edge k+2, count stays 0 throughout.
